mm2s_ctrl: RTL and testbench
============================

Name: mm2s_ctrl

Overview:
- Sequencer that programs the MM2S (memory-to-stream) channel of an AXI DMA engine through an AXI-Lite master front end.
- On `start` it latches the source address (low and high words) and the byte length, then issues the register write sequence: control, source address, source address MSB, length.
- It then waits for the MM2S completion interrupt and clears it with a write to the status register.
- It sits between the system control logic and a separate AXI-Lite write-master block. That block performs each bus write and pulses `lite_end` when the write completes.

Parameters:
- CR_ADDR, 10'h000, MM2S_DMACR offset
- SR_ADDR, 10'h004, MM2S_DMASR offset
- SA_ADDR, 10'h018, MM2S_SA offset
- MSB_ADDR, 10'h01C, MM2S_SA_MSB offset
- LEN_ADDR, 10'h028, MM2S_LENGTH offset
- CR_VAL, 32'h0000_1001, control value (RS=1, IOC_IrqEn=1)
- CLR_VAL, 32'h0000_1000, status write-1-to-clear of IOC_Irq

Ports:
- clk, in, 1, system clock; all logic is on the rising edge
- rst, in, 1, synchronous, active-high reset
- start, in, 1, begin a transfer; sampled only in IDLE
- SA_DATA, in, 32, source address low word; latched on accepted start
- MSB_DATA, in, 32, source address high word; latched on accepted start
- LENGTH_DATA, in, 32, transfer length in bytes; latched on accepted start
- mm2s_introut, in, 1, DMA MM2S interrupt; level, active-high
- lite_end, in, 1, one-cycle pulse from the write master: the current write has completed
- lite_wdata, out, 32, write data for the current write
- lite_awaddr, out, 10, register offset for the current write
- lite_valid, out, 1, one-cycle request pulse: issue a write using the current lite_awaddr and lite_wdata

Behaviour:
- Reset: state=IDLE; lite_wdata=0, lite_awaddr=0, lite_valid=0; latched SA, MSB and LEN registers cleared; irq_pend=0. Reset mid-sequence aborts immediately, and no further writes are requested.
- All outputs are registered.
- lite_valid is high for exactly one cycle per write.
- lite_awaddr and lite_wdata are set on the same edge that raises lite_valid, and are held until the next write is loaded.
- States: IDLE, W_CR, W_SA, W_MSB, W_LEN, WAIT_IRQ, W_CLR.
- IDLE, start=1 at an edge:
  - Latch SA_DATA, MSB_DATA and LENGTH_DATA.
  - Load CR_ADDR and CR_VAL, pulse lite_valid, and go to W_CR.
  - lite_valid is therefore high in the cycle immediately after the start edge.
- W_CR, on lite_end: load SA_ADDR with the latched SA, pulse valid, go to W_SA.
- W_SA, on lite_end: load MSB_ADDR with the latched MSB, pulse valid, go to W_MSB.
- W_MSB, on lite_end: load LEN_ADDR with the latched LEN, pulse valid, go to W_LEN.
- W_LEN, on lite_end, with no pending interrupt:
  - Go to WAIT_IRQ.
  - Address and data hold; no pulse.
- W_LEN, on lite_end, with irq_pend=1 or mm2s_introut=1: load SR_ADDR and CLR_VAL, pulse valid, go to W_CLR.
- WAIT_IRQ, mm2s_introut=1 at an edge: load SR_ADDR and CLR_VAL, pulse valid, go to W_CLR.
- W_CLR, on lite_end: go to IDLE and clear irq_pend.
- Interrupt arriving early: mm2s_introut=1 seen in W_CR..W_LEN sets irq_pend, so the interrupt is not lost.
- lite_end outside a W_* state is ignored.
- Every W_* state waits indefinitely for lite_end; there is no timeout.
- start outside IDLE is ignored. Input data is not re-latched during a sequence.
- mm2s_introut in IDLE is ignored and does not set irq_pend.
- lite_end and mm2s_introut arriving in the same cycle in W_LEN: go straight to W_CLR.
- Values pass through unmodified; there is no arithmetic and no length check. A length of 0 is written as-is.

Decomposition:
- Shared package `dma_regs_pkg`:
  - Register offsets CR, SR, SA, MSB and LEN.
  - CR_VAL and CLR_VAL.
  - State enum.
  - Shared with the S2MM controller.
- Single module with no sub-module. The one-cycle valid pulse is generated inline.

Test Plan:
- Reset for 2 cycles, then start with SA=2, MSB=0, LEN=3 → valid pulse 1 cycle later with awaddr=0x000, wdata=0x00001001. No further pulse until lite_end.
- lite_end three times, 5 cycles apart → successive single valid pulses: (0x018, 2), (0x01C, 0), (0x028, 3).
- Fourth lite_end, then mm2s_introut after 5 cycles → WAIT_IRQ, then pulse with (0x004, 0x00001000). A following lite_end returns to IDLE. A new start is then accepted.
- Raise mm2s_introut during W_SA, then complete the remaining writes → the clear write is issued immediately after the LEN write's lite_end.
- start pulsed with new data during W_MSB → ignored; the LEN write carries the originally latched length.
- Assert rst during W_SA → all outputs 0, state IDLE. A later lite_end causes no pulse.

Source files
------------

// File: rtl/dma_regs_pkg.sv
// AXI DMA register offsets, control/clear values and the sequencer state
// encoding shared by the MM2S and S2MM channel controllers.
package dma_regs_pkg;

  localparam logic [9:0]  CR_ADDR  = 10'h000;
  localparam logic [9:0]  SR_ADDR  = 10'h004;
  localparam logic [9:0]  SA_ADDR  = 10'h018;
  localparam logic [9:0]  MSB_ADDR = 10'h01C;
  localparam logic [9:0]  LEN_ADDR = 10'h028;

  // RS=1 with IOC_IrqEn=1; the clear value is write-1-to-clear of IOC_Irq
  localparam logic [31:0] CR_VAL   = 32'h0000_1001;
  localparam logic [31:0] CLR_VAL  = 32'h0000_1000;

  typedef enum logic [2:0] {
    IDLE,
    W_CR,
    W_SA,
    W_MSB,
    W_LEN,
    WAIT_IRQ,
    W_CLR
  } dma_state_e;

endpackage

// File: rtl/mm2s_ctrl.sv
// MM2S channel sequencer: programs CR, SA, SA_MSB and LENGTH through the
// AXI-Lite write master, then waits for IOC and clears it in SR.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; inputs latched when start is accepted
// W_CR     | control write issued, waiting for lite_end
// W_SA     | source address write issued, waiting for lite_end
// W_MSB    | source address MSB write issued, waiting for lite_end
// W_LEN    | length write issued, waiting for lite_end
// WAIT_IRQ | transfer running, waiting for mm2s_introut
// W_CLR    | status clear write issued, waiting for lite_end
module mm2s_ctrl
  import dma_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] SA_DATA,
  input  logic [31:0] MSB_DATA,
  input  logic [31:0] LENGTH_DATA,
  input  logic        mm2s_introut,
  input  logic        lite_end,
  output logic [31:0] lite_wdata,
  output logic [9:0]  lite_awaddr,
  output logic        lite_valid
);

  dma_state_e  state;
  logic [31:0] sa_q;
  logic [31:0] msb_q;
  logic [31:0] len_q;
  logic        irq_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sa_q        <= '0;
      msb_q       <= '0;
      len_q       <= '0;
      irq_pend    <= 1'b0;
      lite_wdata  <= '0;
      lite_awaddr <= '0;
      lite_valid  <= 1'b0;
    end else begin
      lite_valid <= 1'b0;

      // An interrupt during register programming must survive until W_LEN
      if ((state == W_CR || state == W_SA || state == W_MSB || state == W_LEN) &&
          mm2s_introut)
        irq_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            sa_q        <= SA_DATA;
            msb_q       <= MSB_DATA;
            len_q       <= LENGTH_DATA;
            lite_awaddr <= CR_ADDR;
            lite_wdata  <= CR_VAL;
            lite_valid  <= 1'b1;
            state       <= W_CR;
          end
        end
        W_CR: begin
          if (lite_end) begin
            lite_awaddr <= SA_ADDR;
            lite_wdata  <= sa_q;
            lite_valid  <= 1'b1;
            state       <= W_SA;
          end
        end
        W_SA: begin
          if (lite_end) begin
            lite_awaddr <= MSB_ADDR;
            lite_wdata  <= msb_q;
            lite_valid  <= 1'b1;
            state       <= W_MSB;
          end
        end
        W_MSB: begin
          if (lite_end) begin
            lite_awaddr <= LEN_ADDR;
            lite_wdata  <= len_q;
            lite_valid  <= 1'b1;
            state       <= W_LEN;
          end
        end
        W_LEN: begin
          if (lite_end) begin
            if (irq_pend || mm2s_introut) begin
              lite_awaddr <= SR_ADDR;
              lite_wdata  <= CLR_VAL;
              lite_valid  <= 1'b1;
              state       <= W_CLR;
            end else begin
              state <= WAIT_IRQ;
            end
          end
        end
        WAIT_IRQ: begin
          if (mm2s_introut) begin
            lite_awaddr <= SR_ADDR;
            lite_wdata  <= CLR_VAL;
            lite_valid  <= 1'b1;
            state       <= W_CLR;
          end
        end
        W_CLR: begin
          if (lite_end) begin
            irq_pend <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm2s_ctrl.sv
// Directed bench for mm2s_ctrl: register write ordering, interrupt handling,
// ignored start, zero length and mid-sequence reset.
module tb_mm2s_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] SA_DATA = '0;
  logic [31:0] MSB_DATA = '0;
  logic [31:0] LENGTH_DATA = '0;
  logic        mm2s_introut = 1'b0;
  logic        lite_end = 1'b0;
  logic [31:0] lite_wdata;
  logic [9:0]  lite_awaddr;
  logic        lite_valid;

  int errors = 0;
  int checks = 0;

  mm2s_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .SA_DATA      (SA_DATA),
    .MSB_DATA     (MSB_DATA),
    .LENGTH_DATA  (LENGTH_DATA),
    .mm2s_introut (mm2s_introut),
    .lite_end     (lite_end),
    .lite_wdata   (lite_wdata),
    .lite_awaddr  (lite_awaddr),
    .lite_valid   (lite_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic end_write();
    lite_end = 1'b1;
    tick();
    lite_end = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] sa, input logic [31:0] msb, input logic [31:0] len);
    SA_DATA = sa;
    MSB_DATA = msb;
    LENGTH_DATA = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (lite_valid !== 1'b0 || lite_awaddr !== 10'h000 || lite_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b addr=%h data=%h, want 0/000/00000000",
               lite_valid, lite_awaddr, lite_wdata);
    end
    rst = 1'b0;
    tick();
    end_write();
    checks++;
    if (lite_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_lite_end: got valid=%b, want 0", lite_valid);
    end
  endtask

  task automatic test_cr_write();
    do_start(32'd2, 32'd0, 32'd3);
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h000 || lite_wdata !== 32'h0000_1001) begin
      errors++;
      $display("FAIL cr_write: got valid=%b addr=%h data=%h, want 1/000/00001001",
               lite_valid, lite_awaddr, lite_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (lite_valid !== 1'b0 || lite_awaddr !== 10'h000) begin
        errors++;
        $display("FAIL cr_hold[%0d]: got valid=%b addr=%h, want 0/000", i, lite_valid, lite_awaddr);
      end
    end
  endtask

  task automatic test_reg_writes();
    logic [9:0]  exp_addr [3] = '{10'h018, 10'h01C, 10'h028};
    logic [31:0] exp_data [3] = '{32'd2, 32'd0, 32'd3};
    for (int i = 0; i < 3; i++) begin
      if (i != 0) repeat (4) tick();
      end_write();
      checks++;
      if (lite_valid !== 1'b1 || lite_awaddr !== exp_addr[i] || lite_wdata !== exp_data[i]) begin
        errors++;
        $display("FAIL reg_write[%0d]: got valid=%b addr=%h data=%h, want 1/%h/%h",
                 i, lite_valid, lite_awaddr, lite_wdata, exp_addr[i], exp_data[i]);
      end
      tick();
      checks++;
      if (lite_valid !== 1'b0) begin
        errors++;
        $display("FAIL reg_write_pulse[%0d]: got valid=%b, want 0", i, lite_valid);
      end
    end
  endtask

  task automatic test_wait_irq();
    repeat (3) tick();
    end_write();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (lite_valid !== 1'b0 || lite_awaddr !== 10'h028 || lite_wdata !== 32'd3) begin
        errors++;
        $display("FAIL wait_irq_hold[%0d]: got valid=%b addr=%h data=%h, want 0/028/00000003",
                 i, lite_valid, lite_awaddr, lite_wdata);
      end
      tick();
    end
    mm2s_introut = 1'b1;
    tick();
    mm2s_introut = 1'b0;
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h004 || lite_wdata !== 32'h0000_1000) begin
      errors++;
      $display("FAIL clr_write: got valid=%b addr=%h data=%h, want 1/004/00001000",
               lite_valid, lite_awaddr, lite_wdata);
    end
    tick();
    end_write();
    checks++;
    if (lite_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_done: got valid=%b, want 0", lite_valid);
    end
    do_start(32'h1000_0000, 32'h0000_0001, 32'h0000_0040);
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h000 || lite_wdata !== 32'h0000_1001) begin
      errors++;
      $display("FAIL restart_cr: got valid=%b addr=%h data=%h, want 1/000/00001001",
               lite_valid, lite_awaddr, lite_wdata);
    end
  endtask

  task automatic test_early_irq();
    tick();
    end_write();
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h018 || lite_wdata !== 32'h1000_0000) begin
      errors++;
      $display("FAIL early_sa: got valid=%b addr=%h data=%h, want 1/018/10000000",
               lite_valid, lite_awaddr, lite_wdata);
    end
    mm2s_introut = 1'b1;
    tick();
    mm2s_introut = 1'b0;
    checks++;
    if (lite_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_irq_in_wsa: got valid=%b, want 0", lite_valid);
    end
    end_write();
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h01C || lite_wdata !== 32'h0000_0001) begin
      errors++;
      $display("FAIL early_msb: got valid=%b addr=%h data=%h, want 1/01c/00000001",
               lite_valid, lite_awaddr, lite_wdata);
    end
    end_write();
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h028 || lite_wdata !== 32'h0000_0040) begin
      errors++;
      $display("FAIL early_len: got valid=%b addr=%h data=%h, want 1/028/00000040",
               lite_valid, lite_awaddr, lite_wdata);
    end
    end_write();
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h004 || lite_wdata !== 32'h0000_1000) begin
      errors++;
      $display("FAIL early_clr: got valid=%b addr=%h data=%h, want 1/004/00001000",
               lite_valid, lite_awaddr, lite_wdata);
    end
    tick();
    end_write();
  endtask

  task automatic test_start_ignored();
    do_start(32'd5, 32'd6, 32'd7);
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h000) begin
      errors++;
      $display("FAIL ign_cr: got valid=%b addr=%h, want 1/000", lite_valid, lite_awaddr);
    end
    end_write();
    checks++;
    if (lite_valid !== 1'b1 || lite_wdata !== 32'd5) begin
      errors++;
      $display("FAIL ign_sa: got valid=%b data=%h, want 1/00000005", lite_valid, lite_wdata);
    end
    end_write();
    checks++;
    if (lite_valid !== 1'b1 || lite_wdata !== 32'd6) begin
      errors++;
      $display("FAIL ign_msb: got valid=%b data=%h, want 1/00000006", lite_valid, lite_wdata);
    end
    do_start(32'd9, 32'd9, 32'd99);
    checks++;
    if (lite_valid !== 1'b0 || lite_awaddr !== 10'h01C) begin
      errors++;
      $display("FAIL ign_start: got valid=%b addr=%h, want 0/01c", lite_valid, lite_awaddr);
    end
    end_write();
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h028 || lite_wdata !== 32'd7) begin
      errors++;
      $display("FAIL ign_len: got valid=%b addr=%h data=%h, want 1/028/00000007",
               lite_valid, lite_awaddr, lite_wdata);
    end
    tick();
    lite_end = 1'b1;
    mm2s_introut = 1'b1;
    tick();
    lite_end = 1'b0;
    mm2s_introut = 1'b0;
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h004 || lite_wdata !== 32'h0000_1000) begin
      errors++;
      $display("FAIL same_cycle_clr: got valid=%b addr=%h data=%h, want 1/004/00001000",
               lite_valid, lite_awaddr, lite_wdata);
    end
    tick();
    end_write();
  endtask

  task automatic test_idle_irq_zero_len();
    mm2s_introut = 1'b1;
    tick();
    tick();
    mm2s_introut = 1'b0;
    checks++;
    if (lite_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_irq: got valid=%b, want 0", lite_valid);
    end
    do_start(32'h0, 32'h0, 32'h0);
    end_write();
    end_write();
    end_write();
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h028 || lite_wdata !== 32'h0) begin
      errors++;
      $display("FAIL zero_len: got valid=%b addr=%h data=%h, want 1/028/00000000",
               lite_valid, lite_awaddr, lite_wdata);
    end
    end_write();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lite_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_stale_irq[%0d]: got valid=%b, want 0", i, lite_valid);
      end
      tick();
    end
    mm2s_introut = 1'b1;
    tick();
    mm2s_introut = 1'b0;
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h004) begin
      errors++;
      $display("FAIL zero_len_clr: got valid=%b addr=%h, want 1/004", lite_valid, lite_awaddr);
    end
    tick();
    end_write();
  endtask

  task automatic test_reset_mid();
    do_start(32'h11, 32'h22, 32'h33);
    end_write();
    checks++;
    if (lite_valid !== 1'b1 || lite_awaddr !== 10'h018 || lite_wdata !== 32'h11) begin
      errors++;
      $display("FAIL rst_mid_sa: got valid=%b addr=%h data=%h, want 1/018/00000011",
               lite_valid, lite_awaddr, lite_wdata);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (lite_valid !== 1'b0 || lite_awaddr !== 10'h000 || lite_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got valid=%b addr=%h data=%h, want 0/000/00000000",
               lite_valid, lite_awaddr, lite_wdata);
    end
    end_write();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lite_valid !== 1'b0 || lite_awaddr !== 10'h000) begin
        errors++;
        $display("FAIL rst_mid_no_pulse[%0d]: got valid=%b addr=%h, want 0/000",
                 i, lite_valid, lite_awaddr);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_cr_write();
    test_reg_writes();
    test_wait_irq();
    test_early_irq();
    test_start_ignored();
    test_idle_irq_zero_len();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
